// File: rtl/knn_vote_seq.sv
// Sequential k-NN majority vote: tallies labels of K neighbours one per clock, then scans classes one per clock.
// Optional KNN_VOTE_TIE_NEAREST_EN: ties resolve to the label whose first occurrence is nearest (lowest slot).
module knn_vote_seq #(
  parameter int unsigned W = 15,
  parameter int unsigned K = 4,
  parameter int unsigned L = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W*K-1:0] nn_in,
  output logic [L-1:0]   class_o,
  output logic           valid,
  output logic           busy
);

  localparam int unsigned CW = $clog2(K + 1);
  localparam int unsigned NW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned NC = 1 << L;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          r_state_nxt;
  logic [W-1:0]    r_nn [K];
  logic [CW-1:0]   r_tally [NC];
  logic [NW-1:0]   r_n;
  logic [L-1:0]    r_c;
  logic [CW-1:0]   r_best_tally;
  logic [L-1:0]    r_best_class;
  logic [L-1:0]    r_class;
  logic            r_valid;
  logic            r_busy;

  logic            w_accept;
  logic            w_last_slot;
  logic            w_last_class;
  logic [L-1:0]    w_label;
  logic            w_upd;

`ifdef KNN_VOTE_TIE_NEAREST_EN
  logic [NW-1:0]   r_first [NC];
  assign w_upd = (r_tally[r_c] > r_best_tally) ||
                 ((r_tally[r_c] == r_best_tally) && (r_first[r_c] < r_first[r_best_class]));
`else
  assign w_upd = (r_tally[r_c] > r_best_tally);
`endif

  assign w_label      = r_nn[r_n][W-1 -: L];
  assign w_last_slot  = (r_n == NW'(K - 1));
  assign w_last_class = (r_c == L'(NC - 1));

  assign class_o = r_class;
  assign valid   = r_valid;
  assign busy    = r_busy;

  // Next-state logic; start is honoured only in IDLE and DONE.
  always_comb begin
    r_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          r_state_nxt = S_COUNT;
        end
      end
      S_COUNT: if (w_last_slot) r_state_nxt = S_SCAN;
      S_SCAN:  if (w_last_class) r_state_nxt = S_DONE;
      S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          r_state_nxt = S_COUNT;
        end else begin
          r_state_nxt = S_IDLE;
        end
      end
      default: r_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_c          <= '0;
      r_best_tally <= '0;
      r_best_class <= '0;
      r_class      <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      for (int i = 0; i < int'(K); i++) r_nn[i] <= '0;
      for (int j = 0; j < int'(NC); j++) begin
        r_tally[j] <= '0;
`ifdef KNN_VOTE_TIE_NEAREST_EN
        r_first[j] <= '1;
`endif
      end
    end else begin
      r_state <= r_state_nxt;
      r_valid <= 1'b0;
      r_busy  <= (r_state_nxt == S_COUNT) || (r_state_nxt == S_SCAN);
      if (w_accept) begin
        for (int i = 0; i < int'(K); i++) r_nn[i] <= nn_in[W*i +: W];
        for (int j = 0; j < int'(NC); j++) begin
          r_tally[j] <= '0;
`ifdef KNN_VOTE_TIE_NEAREST_EN
          r_first[j] <= '1;
`endif
        end
        r_n          <= '0;
        r_c          <= '0;
        r_best_tally <= '0;
        r_best_class <= '0;
      end else if (r_state == S_COUNT) begin
`ifdef KNN_VOTE_TIE_NEAREST_EN
        if (r_tally[w_label] == '0) r_first[w_label] <= r_n;
`endif
        r_tally[w_label] <= r_tally[w_label] + CW'(1);
        r_n              <= w_last_slot ? '0 : r_n + NW'(1);
        r_c              <= '0;
      end else if (r_state == S_SCAN) begin
        if (w_upd) begin
          r_best_tally <= r_tally[r_c];
          r_best_class <= r_c;
        end
        r_c <= r_c + L'(1);
        // Final class folds straight into the output so the result is visible in DONE.
        if (w_last_class) begin
          r_class <= w_upd ? r_c : r_best_class;
          r_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_knn_vote_seq.sv
// Scoreboard bench for knn_vote_seq (W=15, K=4, L=2); expected labels are hand-derived per vector.
// Honours KNN_VOTE_TIE_NEAREST_EN for the tie-break vector.
module tb_knn_vote_seq;

  localparam int unsigned W = 15;
  localparam int unsigned K = 4;
  localparam int unsigned L = 2;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W*K-1:0] nn_in;
  logic [L-1:0]   class_o;
  logic           valid;
  logic           busy;

  int errors  = 0;
  int checks  = 0;
  int n_valid = 0;
  int n_push  = 0;
  logic [L-1:0] sb [$];

  knn_vote_seq #(.W(W), .K(K), .L(L)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .nn_in   (nn_in),
    .class_o (class_o),
    .valid   (valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W*K-1:0] mk(input logic [1:0] l0, input logic [1:0] l1,
                                        input logic [1:0] l2, input logic [1:0] l3);
    return {l3, 13'd1207, l2, 13'd407, l1, 13'd1107, l0, 13'd7};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid at %0t: class_o=%0d with no pending request", $time, class_o);
      end else begin
        logic [L-1:0] e;
        e = sb.pop_front();
        if (class_o !== e) begin
          errors++;
          $display("FAIL sb_class at %0t: got %0d expected %0d", $time, class_o, e);
        end
      end
    end
  end

  // One classification from IDLE; optional stray starts in COUNT (t+3) and SCAN (t+6).
  task automatic run(input logic [W*K-1:0] v, input logic [L-1:0] exp, input bit pulse);
    @(negedge clk);
    start = 1'b1;
    nn_in = v;
    sb.push_back(exp);
    n_push++;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk("busy", int'(busy), int'(k <= 8));
      chk("valid", int'(valid), int'(k == 9));
      if (k == 9) chk("class_o", int'(class_o), int'(exp));
      start = pulse && (k == 3 || k == 6);
      @(negedge clk);
    end
    start = 1'b0;
    chk("idle_valid", int'(valid), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    logic [L-1:0] tie_exp;
    rst   = 1'b1;
    start = 1'b0;
    nn_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_class", int'(class_o), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);

    run('0, 2'd0, 1'b0);
    run(mk(2'd2, 2'd2, 2'd1, 2'd3), 2'd2, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_class", int'(class_o), 2);

`ifdef KNN_VOTE_TIE_NEAREST_EN
    tie_exp = 2'd3;
`else
    tie_exp = 2'd1;
`endif
    run(mk(2'd3, 2'd1, 2'd3, 2'd1), tie_exp, 1'b0);
    run(mk(2'd0, 2'd1, 2'd2, 2'd3), 2'd0, 1'b0);
    run(mk(2'd3, 2'd3, 2'd0, 2'd1), 2'd3, 1'b1);

    // Back-to-back: start held through DONE; the second vector is the one present in DONE.
    @(negedge clk);
    start = 1'b1;
    nn_in = mk(2'd1, 2'd2, 2'd2, 2'd0);
    sb.push_back(2'd2);
    n_push++;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      chk("b2b_busy", int'(busy), int'(k <= 8 || (k >= 10 && k <= 17)));
      chk("b2b_valid", int'(valid), int'(k == 9 || k == 18));
      if (k == 8) begin
        start = 1'b1;
        nn_in = mk(2'd3, 2'd3, 2'd3, 2'd3);
        sb.push_back(2'd3);
        n_push++;
      end
      if (k == 10) begin
        start = 1'b0;
        nn_in = mk(2'd1, 2'd1, 2'd1, 2'd1);
      end
      @(negedge clk);
    end

    // Reset in the middle of COUNT discards the run entirely.
    start = 1'b1;
    nn_in = mk(2'd2, 2'd2, 2'd2, 2'd2);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_class", int'(class_o), 0);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_quiet", int'(valid), 0);
    end

    run(mk(2'd1, 2'd1, 2'd1, 2'd0), 2'd1, 1'b0);

    repeat (12) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("valid_count", n_valid, n_push);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
